// File: rtl/id_stage_hs_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_hs_pkg
// Shared definitions for the handshaked instruction-decode stage:
//   - default widths for instruction, PC, register data and register address
//   - opcode / funct encodings of the locally resolved jumps (J, JR)
//   - bit positions of the decoded instruction fields
//   - classify(): maps opcode/funct to the kind of local redirect
// No ports (package).
// -----------------------------------------------------------------------------
package id_stage_hs_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int PC_W_DEF    = 32;
  localparam int GPR_W_DEF   = 32;
  localparam int RA_W_DEF    = 5;

  // Jump encodings resolved inside the decode stage.
  localparam logic [5:0] J_OPC       = 6'h02;
  localparam logic [5:0] SPECIAL_OPC = 6'h00;
  localparam logic [5:0] JR_FUNCT    = 6'h08;

  // Field positions inside a 32-bit instruction word.
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int OPC_W     = 6;
  localparam int FUNCT_W   = 6;
  localparam int IMM_W     = 16;
  localparam int TARGET_W  = 26;

  typedef enum logic [1:0] {
    JK_NONE = 2'd0,
    JK_J    = 2'd1,
    JK_JR   = 2'd2
  } jump_kind_e;

  function automatic jump_kind_e classify(input logic [5:0] opc,
                                          input logic [5:0] funct);
    jump_kind_e k;
    k = JK_NONE;
    if (opc == J_OPC) begin
      k = JK_J;
    end else if ((opc == SPECIAL_OPC) && (funct == JR_FUNCT)) begin
      k = JK_JR;
    end
    return k;
  endfunction

endpackage

// File: rtl/id_fifo.sv
// -----------------------------------------------------------------------------
// id_fifo
// Parametrised circular buffer holding fetched {instr, pc} entries.
// The head entry is presented combinationally so the decode logic can read
// the register file from it in the same cycle.
// Ports:
//   clk    clock
//   rst    asynchronous reset, active-low
//   clear  drop every held entry (wins over push and pop)
//   push   write din at the tail (ignored when full and not popping)
//   pop    retire the head entry (ignored when empty)
//   din    entry to write
//   dout   head entry
//   count  number of held entries (0..DEPTH)
// -----------------------------------------------------------------------------
module id_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic full;
  logic push_ok;
  logic pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so a full buffer still accepts
  // a write when the head is retired.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && (count_reg != '0);

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push_ok && !clear) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/id_stage_hs.sv
// -----------------------------------------------------------------------------
// id_stage_hs
// Handshaked instruction-decode stage between IF and EX. Buffers up to DEPTH
// fetched instructions, reads the register file for the head entry, registers
// a decoded bundle towards EX and resolves J/JR locally with a one-cycle
// redirect pulse to IF.
//
// Optional build macro: ID_BYPASS_EN -- adds the write-back bypass ports
// (wb_we, wb_addr, wb_data) that override register-file read data.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid/in_ready        IF handshake (in_ready = buffer not full)
//   in_instr, in_pc          fetched instruction and its PC
//   flush                    kill all held work (branch taken downstream)
//   hazard_stall             hold the head instruction
//   rf_rs, rf_rt             clamped register-file read addresses
//   rf_data_rs, rf_data_rt   register-file read data (combinational)
//   wb_we/wb_addr/wb_data    write-back bypass (ID_BYPASS_EN only)
//   jump_valid, jump_addr    one-cycle redirect pulse and its target
//   out_valid/out_ready      EX handshake
//   out_opcode..out_next_pc  registered decoded bundle
// -----------------------------------------------------------------------------
module id_stage_hs
  import id_stage_hs_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int GPR_W    = GPR_W_DEF,
  parameter int RA_W     = RA_W_DEF,
  parameter int NUM_REGS = 16,
  parameter int DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  input  logic               hazard_stall,
  output logic [RA_W-1:0]    rf_rs,
  output logic [RA_W-1:0]    rf_rt,
  input  logic [GPR_W-1:0]   rf_data_rs,
  input  logic [GPR_W-1:0]   rf_data_rt,
`ifdef ID_BYPASS_EN
  input  logic               wb_we,
  input  logic [RA_W-1:0]    wb_addr,
  input  logic [GPR_W-1:0]   wb_data,
`endif
  output logic               jump_valid,
  output logic [PC_W-1:0]    jump_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         out_opcode,
  output logic [5:0]         out_funct,
  output logic [RA_W-1:0]    out_rd,
  output logic [RA_W-1:0]    out_rs,
  output logic [RA_W-1:0]    out_rt,
  output logic [GPR_W-1:0]   out_imm,
  output logic [GPR_W-1:0]   out_data_rs,
  output logic [GPR_W-1:0]   out_data_rt,
  output logic [PC_W-1:0]    out_next_pc
);

  localparam int ENTRY_W = INSTR_W + PC_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  localparam logic [RA_W:0]   NUM_REGS_X = (RA_W + 1)'(NUM_REGS);
  localparam logic [RA_W-1:0] MAX_RA     = RA_W'(NUM_REGS - 1);

  // ---------------------------------------------------------------------------
  // Input buffer
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] head_entry;
  logic [CNT_W-1:0]   count;
  logic               fifo_clear;
  logic               fifo_push;
  logic               issue;

  logic               jump_valid_reg;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign fifo_push = in_valid && in_ready;
  // The cycle carrying the redirect pulse is the wrong-path window: whatever
  // is still buffered, plus anything pushed during the pulse, is discarded.
  assign fifo_clear = flush || jump_valid_reg;

  id_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (issue),
    .din   ({in_instr, in_pc}),
    .dout  (head_entry),
    .count (count)
  );

  // ---------------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------------
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;
  logic [5:0]         head_opcode;
  logic [5:0]         head_funct;
  logic [RA_W-1:0]    head_rs;
  logic [RA_W-1:0]    head_rt;
  logic [RA_W-1:0]    head_rd;
  logic [GPR_W-1:0]   head_imm;
  jump_kind_e         head_jump;

  assign head_instr  = head_entry[ENTRY_W-1 -: INSTR_W];
  assign head_pc     = head_entry[PC_W-1:0];
  assign head_opcode = head_instr[OPC_LSB +: OPC_W];
  assign head_funct  = head_instr[FUNCT_LSB +: FUNCT_W];
  assign head_rs     = head_instr[RS_LSB +: RA_W];
  assign head_rt     = head_instr[RT_LSB +: RA_W];
  assign head_rd     = head_instr[RD_LSB +: RA_W];
  assign head_imm    = {{(GPR_W - IMM_W){head_instr[IMM_W-1]}}, head_instr[IMM_W-1:0]};
  assign head_jump   = classify(head_opcode, head_funct);

  // Unimplemented register indices alias the top implemented register.
  function automatic logic [RA_W-1:0] clamp_ra(input logic [RA_W-1:0] a);
    return ({1'b0, a} >= NUM_REGS_X) ? MAX_RA : a;
  endfunction

  assign rf_rs = clamp_ra(head_rs);
  assign rf_rt = clamp_ra(head_rt);

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  logic [GPR_W-1:0] opnd_rs;
  logic [GPR_W-1:0] opnd_rt;

`ifdef ID_BYPASS_EN
  // Register 0 is hard-wired, so a write to it must never be forwarded.
  always_comb begin
    opnd_rs = rf_data_rs;
    opnd_rt = rf_data_rt;
    if (wb_we && (wb_addr == rf_rs) && (rf_rs != '0)) begin
      opnd_rs = wb_data;
    end
    if (wb_we && (wb_addr == rf_rt) && (rf_rt != '0)) begin
      opnd_rt = wb_data;
    end
  end
`else
  assign opnd_rs = rf_data_rs;
  assign opnd_rt = rf_data_rt;
`endif

  // ---------------------------------------------------------------------------
  // Issue and jump target
  // ---------------------------------------------------------------------------
  logic            out_valid_reg;
  logic [PC_W-1:0] jump_target;

  // No issue during the redirect pulse: the head at that point is already
  // wrong-path and is about to be discarded.
  assign issue = (count != '0) && !hazard_stall && !flush && !jump_valid_reg &&
                 (out_ready || !out_valid_reg);

  always_comb begin
    jump_target = '0;
    case (head_jump)
      JK_J:    jump_target = {{(PC_W - TARGET_W){1'b0}}, head_instr[TARGET_W-1:0]};
      JK_JR:   jump_target = PC_W'(opnd_rs);
      default: jump_target = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output bundle register
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]  jump_addr_reg;
  logic [5:0]       opcode_reg;
  logic [5:0]       funct_reg;
  logic [RA_W-1:0]  rd_reg;
  logic [RA_W-1:0]  rs_reg;
  logic [RA_W-1:0]  rt_reg;
  logic [GPR_W-1:0] imm_reg;
  logic [GPR_W-1:0] data_rs_reg;
  logic [GPR_W-1:0] data_rt_reg;
  logic [PC_W-1:0]  next_pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg  <= 1'b0;
      jump_valid_reg <= 1'b0;
      jump_addr_reg  <= '0;
      opcode_reg     <= '0;
      funct_reg      <= '0;
      rd_reg         <= '0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      imm_reg        <= '0;
      data_rs_reg    <= '0;
      data_rt_reg    <= '0;
      next_pc_reg    <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      jump_valid_reg <= 1'b0;
    end else if (issue) begin
      out_valid_reg  <= 1'b1;
      jump_valid_reg <= (head_jump != JK_NONE);
      if (head_jump != JK_NONE) begin
        jump_addr_reg <= jump_target;
      end
      opcode_reg  <= head_opcode;
      funct_reg   <= head_funct;
      rd_reg      <= head_rd;
      rs_reg      <= head_rs;
      rt_reg      <= head_rt;
      imm_reg     <= head_imm;
      data_rs_reg <= opnd_rs;
      data_rt_reg <= opnd_rt;
      next_pc_reg <= head_pc + PC_W'(1);
    end else begin
      jump_valid_reg <= 1'b0;
      // Consumed and nothing new: bubble, fields keep their last values.
      if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign jump_valid  = jump_valid_reg;
  assign jump_addr   = jump_addr_reg;
  assign out_valid   = out_valid_reg;
  assign out_opcode  = opcode_reg;
  assign out_funct   = funct_reg;
  assign out_rd      = rd_reg;
  assign out_rs      = rs_reg;
  assign out_rt      = rt_reg;
  assign out_imm     = imm_reg;
  assign out_data_rs = data_rs_reg;
  assign out_data_rt = data_rt_reg;
  assign out_next_pc = next_pc_reg;

endmodule

// File: tb/tb_id_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_id_stage_hs
// Directed bench for id_stage_hs (DEPTH=2, NUM_REGS=16). Expected bundles and
// jump targets are computed from the stimulus and queued when an instruction
// is sent; they are popped when the DUT hands a bundle to EX or raises a
// jump pulse. Honours ID_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_id_stage_hs;

  localparam int DEPTH    = 2;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [5:0]  opc;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [31:0] drs;
    logic [31:0] drt;
    logic [31:0] npc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        hazard_stall;
  logic [4:0]  rf_rs;
  logic [4:0]  rf_rt;
  logic [31:0] rf_data_rs;
  logic [31:0] rf_data_rt;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [31:0] out_imm;
  logic [31:0] out_data_rs;
  logic [31:0] out_data_rt;
  logic [31:0] out_next_pc;
`ifdef ID_BYPASS_EN
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`endif

  logic [31:0] rf_mem [32];

  int errors  = 0;
  int checks  = 0;
  int jpulses = 0;

  bundle_t     exp_q[$];
  logic [31:0] jexp_q[$];

  always #5 clk = ~clk;

  // Register-file model answering the DUT's read addresses.
  assign rf_data_rs = rf_mem[rf_rs];
  assign rf_data_rt = rf_mem[rf_rt];

  id_stage_hs #(
    .INSTR_W  (32),
    .PC_W     (32),
    .GPR_W    (32),
    .RA_W     (5),
    .NUM_REGS (NUM_REGS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .rf_rs        (rf_rs),
    .rf_rt        (rf_rt),
    .rf_data_rs   (rf_data_rs),
    .rf_data_rt   (rf_data_rt),
`ifdef ID_BYPASS_EN
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
`endif
    .jump_valid   (jump_valid),
    .jump_addr    (jump_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_funct    (out_funct),
    .out_rd       (out_rd),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_imm      (out_imm),
    .out_data_rs  (out_data_rs),
    .out_data_rt  (out_data_rt),
    .out_next_pc  (out_next_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, req);
    end
  endtask

  function automatic logic [4:0] clampf(input logic [4:0] a);
    return (int'(a) >= NUM_REGS) ? 5'(NUM_REGS - 1) : a;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t    b;
    logic [4:0] crs;
    logic [4:0] crt;
    crs     = clampf(ins[25:21]);
    crt     = clampf(ins[20:16]);
    b.opc   = ins[31:26];
    b.funct = ins[5:0];
    b.rd    = ins[15:11];
    b.rs    = ins[25:21];
    b.rt    = ins[20:16];
    b.imm   = {{16{ins[15]}}, ins[15:0]};
    b.drs   = rf_mem[crs];
    b.drt   = rf_mem[crt];
`ifdef ID_BYPASS_EN
    if (wb_we && wb_addr == crs && crs != 5'd0) b.drs = wb_data;
    if (wb_we && wb_addr == crt && crt != 5'd0) b.drt = wb_data;
`endif
    b.npc   = pc + 32'd1;
    return b;
  endfunction

  // One clock: observe at the falling edge, then return just after the rising
  // edge so the caller can drive the next inputs.
  task automatic cyc();
    bundle_t e;
    logic [31:0] j;
    @(negedge clk);
    if (jump_valid) begin
      jpulses++;
      checks++;
      assert (jexp_q.size() > 0) else begin
        errors++;
        $error("FAIL jump_unexpected: observed=0x%08h expected=none", jump_addr);
      end
      if (jexp_q.size() > 0) begin
        j = jexp_q.pop_front();
        chk("jump_addr", jump_addr, j);
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL bundle_unexpected: observed next_pc=0x%08h expected=none", out_next_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("bundle pc+1=0x%08h op=%02h fn=%02h rs=%0d rt=%0d rd=%0d drs=0x%08h",
                 out_next_pc, out_opcode, out_funct, out_rs, out_rt, out_rd, out_data_rs);
        chk("next_pc", out_next_pc, e.npc);
        chk("fields", {5'd0, out_opcode, out_funct, out_rd, out_rs, out_rt},
                      {5'd0, e.opc, e.funct, e.rd, e.rs, e.rt});
        chk("imm", out_imm, e.imm);
        chk("data_rs", out_data_rs, e.drs);
        chk("data_rt", out_data_rt, e.drt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for in_ready, take the push edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit expect_out);
    bundle_t b;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    if (expect_out) begin
      b = model(ins, pc);
      exp_q.push_back(b);
      if (ins[31:26] == 6'h02) jexp_q.push_back({6'd0, ins[25:0]});
      else if (ins[31:26] == 6'h00 && ins[5:0] == 6'h08) jexp_q.push_back(b.drs);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000 + 32'(i);
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_instr     = '0;
    in_pc        = '0;
    flush        = 1'b0;
    hazard_stall = 1'b0;
    out_ready    = 1'b0;
`ifdef ID_BYPASS_EN
    wb_we   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
`endif

    // Reset state
    #2 rst = 1'b0;
    flush = 1'b1;
    #10;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_jump_valid", {31'd0, jump_valid}, 32'd0);
    chk("rst_next_pc", out_next_pc, 32'd0);
    chk("rst_jump_addr", jump_addr, 32'd0);
    flush = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Three in-order instructions, buffer fills while the head is stalled
    hazard_stall = 1'b1;
    send(itype(6'h08, 5'd1, 5'd2, 16'hFFF0), 32'h10, 1'b1);
    send(rtype(5'd4, 5'd5, 5'd6, 6'h20), 32'h11, 1'b1);
    chk("in_ready_full", {31'd0, in_ready}, 32'd0);
    hazard_stall = 1'b0;
    send(itype(6'h23, 5'd7, 5'd8, 16'h0004), 32'h12, 1'b1);
    repeat (4) cyc();
    chk("order_drained", exp_q.size(), 32'd0);

    // J at head with younger entries behind it and a push during the pulse
    jpulses = 0;
    hazard_stall = 1'b1;
    send({6'h02, 26'h000040}, 32'h20, 1'b1);
    send(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h21, 1'b0);
    hazard_stall = 1'b0;
    in_valid = 1'b1;
    in_instr = rtype(5'd2, 5'd3, 5'd4, 6'h22);
    in_pc    = 32'h22;
    cyc();
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("j_pulses", 32'(jpulses), 32'd1);
    chk("j_drained", exp_q.size(), 32'd0);

    // JR through register 3
    rf_mem[3] = 32'h1234;
    jpulses = 0;
    send(rtype(5'd3, 5'd0, 5'd0, 6'h08), 32'h30, 1'b1);
    repeat (4) cyc();
    chk("jr_pulses", 32'(jpulses), 32'd1);
    chk("jr_jexp_empty", jexp_q.size(), 32'd0);

    // Hazard stall for two cycles gives two bubbles, then the head issues once
    send(rtype(5'd9, 5'd10, 5'd11, 6'h21), 32'h40, 1'b1);
    send(itype(6'h0D, 5'd12, 5'd13, 16'h8000), 32'h41, 1'b1);
    hazard_stall = 1'b1;
    cyc();
    chk("bubble1", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("bubble2", {31'd0, out_valid}, 32'd0);
    chk("bubble_hold", out_next_pc, 32'h41);
    hazard_stall = 1'b0;
    cyc();
    chk("stall_release", {31'd0, out_valid}, 32'd1);
    chk("stall_release_pc", out_next_pc, 32'h42);
    repeat (3) cyc();
    chk("stall_drained", exp_q.size(), 32'd0);

    // Flush with full buffer and a held bundle
    out_ready = 1'b0;
    send(rtype(5'd1, 5'd1, 5'd1, 6'h20), 32'h50, 1'b0);
    send(rtype(5'd2, 5'd2, 5'd2, 6'h20), 32'h51, 1'b0);
    send(rtype(5'd3, 5'd3, 5'd3, 6'h20), 32'h52, 1'b0);
    chk("flush_pre_full", {31'd0, in_ready}, 32'd0);
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = rtype(5'd4, 5'd4, 5'd4, 6'h20);
    in_pc    = 32'h53;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_empty", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (4) cyc();

    // Flush with an accepted simultaneous push: both entries vanish
    send(rtype(5'd5, 5'd5, 5'd5, 6'h20), 32'h60, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = rtype(5'd6, 5'd6, 5'd6, 6'h20);
    in_pc    = 32'h61;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (4) cyc();
    chk("flush2_no_jump", 32'(jpulses), 32'd1);

    // Register-address clamp (and bypass when built in)
`ifdef ID_BYPASS_EN
    wb_we   = 1'b1;
    wb_addr = 5'd15;
    wb_data = 32'hBEEF;
`endif
    hazard_stall = 1'b1;
    send(rtype(5'd20, 5'd2, 5'd5, 6'h20), 32'h70, 1'b1);
    chk("clamp_rf_rs", {27'd0, rf_rs}, 32'd15);
    chk("clamp_rf_rt", {27'd0, rf_rt}, 32'd2);
    hazard_stall = 1'b0;
    repeat (3) cyc();
`ifdef ID_BYPASS_EN
    chk("bypass_data_rs", out_data_rs, 32'hBEEF);
    wb_addr = 5'd0;
    wb_data = 32'hDEAD;
    send(rtype(5'd0, 5'd0, 5'd1, 6'h20), 32'h71, 1'b1);
    repeat (3) cyc();
    wb_we = 1'b0;
`endif

    // Wrap of out_next_pc
    send(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'hFFFF_FFFF, 1'b1);
    repeat (3) cyc();

    chk("final_exp_q", exp_q.size(), 32'd0);
    chk("final_jexp_q", jexp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
